// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg
// Shared types and encodings for the multicycle ARM control unit: the
// sequencing FSM state enum, the 3-bit ALU operation codes, the mux select
// encodings driven towards the datapath, and the data-processing cmd opcodes
// together with a helper that turns a cmd into its ALU operation.
// No ports; imported by arm_mc_controller and arm_mc_condlogic.
package arm_mc_pkg;

    // Main sequencing FSM states.
    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } statetype_t;

    // ALU operation encoding shared with the single-cycle design.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    // ResultSrc encodings.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA / ALUSrcB encodings.
    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Instruction class, Instr[27:26].
    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    // Data-processing cmd field, Instr[24:21].
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Decoded view of a cmd: the ALU operation, whether the cmd is one we
    // implement, whether it is CMP (never writes a register) and whether it
    // is arithmetic (so C and V are meaningful).
    typedef struct packed {
        logic [2:0] alu_control;
        logic       valid;
        logic       is_cmp;
        logic       arith;
    } cmd_decode_t;

    // Unsupported cmds fall back to an add with valid cleared, which the
    // FSM uses to suppress the register write.
    function automatic cmd_decode_t decode_cmd(input logic [3:0] cmd);
        cmd_decode_t d;
        d.alu_control = ALU_ADD;
        d.valid       = 1'b1;
        d.is_cmp      = 1'b0;
        d.arith       = 1'b0;
        case (cmd)
            CMD_ADD: begin
                d.alu_control = ALU_ADD;
                d.arith       = 1'b1;
            end
            CMD_SUB: begin
                d.alu_control = ALU_SUB;
                d.arith       = 1'b1;
            end
            CMD_CMP: begin
                d.alu_control = ALU_SUB;
                d.arith       = 1'b1;
                d.is_cmp      = 1'b1;
            end
            CMD_AND: d.alu_control = ALU_AND;
            CMD_ORR: d.alu_control = ALU_ORR;
            CMD_EOR: d.alu_control = ALU_EOR;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arm_mc_condlogic.sv
// arm_mc_condlogic
// Holds the NZCV flag register and the registered condition-pass bit, and
// gates the raw write requests from the FSM with that bit.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   cond           condition field Instr[31:28]
//   alu_flags      N,Z,C,V from the ALU
//   flag_w         [1] update N,Z  [0] update C,V (only non-zero in EXECR/EXECI)
//   cond_latch     high in DECODE: capture the condition result this edge
//   reg_w, mem_w   raw register / memory write requests
//   branch         raw branch request
//   next_pc        unconditional PC update (instruction fetch)
//   rd_is_pc       destination register is R15
//   reg_write, mem_write, pc_write   gated write enables
module arm_mc_condlogic
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       cond_latch,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       branch,
    input  logic       next_pc,
    input  logic       rd_is_pc,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_write
);

    logic [3:0] flags;
    logic       cond_ex_r;
    logic       cond_pass;

    // Evaluates one of the ARM condition codes against stored N,Z,C,V.
    // 1111 is treated as "never" rather than the unconditional space.
    function automatic logic cond_holds(input logic [3:0] code, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic ge;
        logic result;
        n  = nzcv[3];
        z  = nzcv[2];
        c  = nzcv[1];
        v  = nzcv[0];
        ge = (n == v);
        case (code)
            4'b0000: result = z;
            4'b0001: result = ~z;
            4'b0010: result = c;
            4'b0011: result = ~c;
            4'b0100: result = n;
            4'b0101: result = ~n;
            4'b0110: result = v;
            4'b0111: result = ~v;
            4'b1000: result = c & ~z;
            4'b1001: result = ~c | z;
            4'b1010: result = ge;
            4'b1011: result = ~ge;
            4'b1100: result = ~z & ge;
            4'b1101: result = z | ~ge;
            4'b1110: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    assign cond_pass = cond_holds(cond, flags);

    // The condition is judged once, in DECODE, and held for the rest of the
    // instruction so that flag updates in EXECR/EXECI cannot change the
    // verdict of the instruction that produced them. Flag updates are
    // themselves conditional on that held verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags     <= 4'b0000;
            cond_ex_r <= 1'b0;
        end else begin
            if (cond_latch) begin
                cond_ex_r <= cond_pass;
            end
            if (flag_w[1] && cond_ex_r) begin
                flags[3:2] <= alu_flags[3:2];
            end
            if (flag_w[0] && cond_ex_r) begin
                flags[1:0] <= alu_flags[1:0];
            end
        end
    end

    // Instruction fetch advances the PC regardless of condition; everything
    // else that writes state needs the held condition to pass. Reset blocks
    // every write so an aborted instruction commits nothing.
    always_comb begin
        reg_write = ~reset & reg_w & cond_ex_r;
        mem_write = ~reset & mem_w & cond_ex_r;
        pc_write  = ~reset & (next_pc | ((branch | (reg_w & rd_is_pc)) & cond_ex_r));
    end

endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller
// Control unit for the multicycle ARM datapath: main sequencing FSM,
// instruction decode and the gated write enables (via arm_mc_condlogic).
// All outputs are Moore-style, combinational from state, Instr, the held
// condition bit and reset.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   Instr        Instr[31:12] from the instruction register
//   ALUFlags     N,Z,C,V from the ALU (meaningful in EXECR/EXECI)
//   PCWrite, IRWrite, RegWrite, MemWrite   datapath write enables
//   AdrSrc       memory address select (0 PC, 1 ALUOut)
//   RegSrc       [0] read PC as Rn, [1] read Rd as second source
//   ImmSrc       immediate extension type (Instr[27:26])
//   ALUSrcA/B    ALU operand selects
//   ResultSrc    result bus select
//   ALUControl   ALU operation
//   BrL          select R14 as write address for BL
module arm_mc_controller
    import arm_mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ALUControl,
    output logic        BrL
);

    statetype_t  state;
    statetype_t  cur_state;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic        imm_op;
    logic [3:0]  cmd;
    logic        s_bit;
    logic        load_bit;
    logic        up_bit;
    logic        link_bit;
    logic [3:0]  rd;
    logic        unused_rn;
    cmd_decode_t dec;

    logic        ir_write_raw;
    logic        next_pc;
    logic        reg_w;
    logic        mem_w;
    logic        branch;
    logic [1:0]  flag_w;

    // Instr carries bits 31:12 only, so every field sits 12 below its
    // architectural position. Rn (bits 19:16) is routed by the datapath
    // and plays no part in control.
    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign imm_op    = Instr[13];
    assign cmd       = Instr[12:9];
    assign link_bit  = Instr[12];
    assign up_bit    = Instr[11];
    assign s_bit     = Instr[8];
    assign load_bit  = Instr[8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];
    assign dec       = decode_cmd(cmd);

    // While reset is held the outputs present the FETCH controls so the
    // datapath sees a well-defined setting before the first real cycle.
    assign cur_state = reset ? FETCH : state;

    // Sequencing: every instruction starts at FETCH/DECODE and branches by
    // class in DECODE; undefined class 11 returns straight to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_MEM:    state <= MEMADR;
                        OP_DP:     state <= imm_op ? EXECI : EXECR;
                        OP_BRANCH: state <= BRANCH;
                        default:   state <= FETCH;
                    endcase
                end
                MEMADR: state <= load_bit ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                EXECR:  state <= ALUWB;
                EXECI:  state <= ALUWB;
                MEMWB,
                MEMWR,
                ALUWB,
                BRANCH: state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Per-state datapath controls and raw write requests. The raw requests
    // are gated by the held condition in arm_mc_condlogic. FETCH and DECODE
    // both compute PC+4 so that DECODE leaves PC+8 visible for R15 reads.
    always_comb begin
        ir_write_raw = 1'b0;
        next_pc      = 1'b0;
        reg_w        = 1'b0;
        mem_w        = 1'b0;
        branch       = 1'b0;
        flag_w       = 2'b00;
        AdrSrc       = 1'b0;
        ALUSrcA      = SRCA_RD1;
        ALUSrcB      = SRCB_RD2;
        ResultSrc    = RES_ALUOUT;
        ALUControl   = ALU_ADD;
        BrL          = 1'b0;
        case (cur_state)
            FETCH: begin
                ir_write_raw = 1'b1;
                next_pc      = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                ALUControl   = ALU_ADD;
            end
            DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR: begin
                ALUSrcB    = SRCB_EXTIMM;
                ALUControl = up_bit ? ALU_ADD : ALU_SUB;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            EXECR,
            EXECI: begin
                ALUSrcB    = (cur_state == EXECI) ? SRCB_EXTIMM : SRCB_RD2;
                ALUControl = dec.alu_control;
                if (dec.is_cmp) begin
                    flag_w = 2'b11;
                end else begin
                    flag_w = {s_bit, s_bit & dec.arith};
                end
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_w     = dec.valid & ~dec.is_cmp;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
                reg_w     = link_bit;
                BrL       = link_bit;
            end
            default: begin
                ir_write_raw = 1'b0;
            end
        endcase
    end

    // Register-port routing depends only on the instruction class.
    always_comb begin
        ImmSrc = op;
        RegSrc = {(op == OP_MEM) & ~load_bit, (op == OP_BRANCH)};
    end

    assign IRWrite = ir_write_raw & ~reset;

    arm_mc_condlogic u_condlogic (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .alu_flags  (ALUFlags),
        .flag_w     (flag_w),
        .cond_latch (cur_state == DECODE),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .branch     (branch),
        .next_pc    (next_pc),
        .rd_is_pc   (rd == 4'hF),
        .reg_write  (RegWrite),
        .mem_write  (MemWrite),
        .pc_write   (PCWrite)
    );

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller
// Drives instruction sequences into arm_mc_controller one cycle at a time.
// Each cycle's expected output vector is produced from a table of the
// per-state controls and pushed to a scoreboard as the stimulus is applied;
// it is popped and compared against the DUT on the following falling edge.
module tb_arm_mc_controller;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } tb_state_t;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       regw;
        logic       memw;
        logic       adr;
        logic [1:0] regsrc;
        logic [1:0] immsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] ressrc;
        logic [2:0] alu;
        logic       brl;
    } outs_t;

    typedef struct {
        tb_state_t  s;
        logic [19:0] ins;
        logic [3:0] flags;
        logic       pass;
        logic       rst;
        string      tag;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] Instr = 20'hE0821;
    logic [3:0]  ALUFlags = 4'b0000;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [2:0]  ALUControl;
    logic        BrL;

    stim_t stim_q[$];
    outs_t sb[$];
    string cur_label;
    int    checks = 0;
    int    errors = 0;
    outs_t got;
    outs_t want;

    arm_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .BrL        (BrL)
    );

    always #5 clk = ~clk;

    // Expected controls for one state of a given instruction; pass is the
    // condition verdict worked out by hand for that instruction.
    function automatic outs_t model(tb_state_t s, logic [19:0] ins, logic pass);
        outs_t      o;
        logic [1:0] op;
        logic [2:0] alu;
        logic       writes_rd;
        logic       rd15;
        o         = '0;
        op        = ins[15:14];
        rd15      = (ins[3:0] == 4'hF);
        o.immsrc  = op;
        o.regsrc  = {(op == 2'b01) && !ins[8], (op == 2'b10)};
        writes_rd = 1'b1;
        alu       = 3'b000;
        case (ins[12:9])
            4'b0100: alu = 3'b000;
            4'b0010: alu = 3'b001;
            4'b1010: begin alu = 3'b001; writes_rd = 1'b0; end
            4'b0000: alu = 3'b010;
            4'b1100: alu = 3'b011;
            4'b0001: alu = 3'b100;
            default: writes_rd = 1'b0;
        endcase
        case (s)
            S_FETCH:  begin o.irw = 1; o.pcw = 1; o.srca = 2'b01; o.srcb = 2'b10; o.ressrc = 2'b10; end
            S_DECODE: begin o.srca = 2'b01; o.srcb = 2'b10; o.ressrc = 2'b10; end
            S_MEMADR: begin o.srcb = 2'b01; o.alu = ins[11] ? 3'b000 : 3'b001; end
            S_MEMRD:  o.adr = 1;
            S_MEMWB:  begin o.ressrc = 2'b01; o.regw = pass; o.pcw = pass & rd15; end
            S_MEMWR:  begin o.adr = 1; o.memw = pass; end
            S_EXECR:  o.alu = alu;
            S_EXECI:  begin o.srcb = 2'b01; o.alu = alu; end
            S_ALUWB:  begin o.regw = pass & writes_rd; o.pcw = pass & writes_rd & rd15; end
            S_BRANCH: begin
                o.srcb = 2'b01; o.ressrc = 2'b10; o.pcw = pass;
                o.regw = pass & ins[12]; o.brl = ins[12];
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic outs_t observed();
        outs_t o;
        o.pcw    = PCWrite;
        o.irw    = IRWrite;
        o.regw   = RegWrite;
        o.memw   = MemWrite;
        o.adr    = AdrSrc;
        o.regsrc = RegSrc;
        o.immsrc = ImmSrc;
        o.srca   = ALUSrcA;
        o.srcb   = ALUSrcB;
        o.ressrc = ResultSrc;
        o.alu    = ALUControl;
        o.brl    = BrL;
        return o;
    endfunction

    // Queues the walk of one instruction through n states.
    task automatic add_instr(input string tag, input logic [19:0] ins, input logic [3:0] fl,
                             input logic pass, input int n, input tb_state_t s0, input tb_state_t s1,
                             input tb_state_t s2, input tb_state_t s3, input tb_state_t s4);
        tb_state_t path [5];
        path = '{s0, s1, s2, s3, s4};
        for (int i = 0; i < n; i++) begin
            stim_t e;
            e.s = path[i]; e.ins = ins; e.flags = fl; e.pass = pass; e.rst = 1'b0; e.tag = tag;
            stim_q.push_back(e);
        end
    endtask

    task automatic add_reset(input string tag, input logic [19:0] ins, input tb_state_t s);
        stim_t e;
        e.s = s; e.ins = ins; e.flags = 4'b0000; e.pass = 1'b0; e.rst = 1'b1; e.tag = tag;
        stim_q.push_back(e);
    endtask

    // Applies the next queued cycle of stimulus just after a rising edge,
    // records what the DUT must show, and waits for the falling edge.
    task automatic apply_stimulus();
        stim_t cur;
        outs_t e;
        cur      = stim_q.pop_front();
        reset    = cur.rst;
        Instr    = cur.ins;
        ALUFlags = cur.flags;
        e        = model(cur.rst ? S_FETCH : cur.s, cur.ins, cur.pass);
        if (cur.rst) begin
            e.pcw = 1'b0; e.irw = 1'b0; e.regw = 1'b0; e.memw = 1'b0;
        end
        sb.push_back(e);
        cur_label = $sformatf("%s/%s%s", cur.tag, cur.s.name(), cur.rst ? "+reset" : "");
        @(negedge clk);
    endtask

    task automatic test_reset();
        add_reset("reset", 20'hE0821, S_FETCH);
        add_reset("reset", 20'hE0821, S_FETCH);
        add_instr("add", 20'hE0821, 4'b0000, 1'b1, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH);
        while (stim_q.size() > 0) begin
            apply_stimulus();
            want = sb.pop_front(); got = observed(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset %s: got %b want %b", cur_label, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        add_instr("ldr", 20'hE5910, 4'b0000, 1'b1, 5, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB);
        while (stim_q.size() > 0) begin
            apply_stimulus();
            want = sb.pop_front(); got = observed(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL load %s: got %b want %b", cur_label, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0] cmds [4];
        cmds = '{4'b0000, 4'b1100, 4'b0001, 4'b0111};
        foreach (cmds[i]) begin
            add_instr($sformatf("dp_cmd%b", cmds[i]), {4'hE, 2'b00, 1'b0, cmds[i], 1'b0, 4'h2, 4'h1},
                      4'b0000, 1'b1, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH);
        end
        add_instr("add_pc_imm", 20'hE281F, 4'b0000, 1'b1, 4, S_FETCH, S_DECODE, S_EXECI, S_ALUWB, S_FETCH);
        while (stim_q.size() > 0) begin
            apply_stimulus();
            want = sb.pop_front(); got = observed(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL alu_ops %s: got %b want %b", cur_label, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flags_branch();
        add_instr("subs_z",   20'hE0510, 4'b0100, 1'b1, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH);
        add_instr("beq_take", 20'h0A000, 4'b0000, 1'b1, 3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH);
        add_instr("subsne",   20'h10510, 4'b0000, 1'b0, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH);
        add_instr("beq_kept", 20'h0A000, 4'b0000, 1'b1, 3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH);
        add_instr("adds_nz",  20'hE0921, 4'b0000, 1'b1, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH);
        add_instr("beq_skip", 20'h0A000, 4'b0000, 1'b0, 3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH);
        while (stim_q.size() > 0) begin
            apply_stimulus();
            want = sb.pop_front(); got = observed(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL flags_branch %s: got %b want %b", cur_label, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bl();
        add_instr("bl", 20'hEB000, 4'b0000, 1'b1, 3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH);
        while (stim_q.size() > 0) begin
            apply_stimulus();
            want = sb.pop_front(); got = observed(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL bl %s: got %b want %b", cur_label, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cond_store();
        add_instr("cmp_z",  20'hE1510, 4'b0100, 1'b1, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH);
        add_instr("strne",  20'h15810, 4'b0000, 1'b0, 4, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH);
        add_instr("str_al", 20'hE5810, 4'b0000, 1'b1, 4, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH);
        while (stim_q.size() > 0) begin
            apply_stimulus();
            want = sb.pop_front(); got = observed(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL cond_store %s: got %b want %b", cur_label, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_undefined();
        add_instr("undef", 20'hEC000, 4'b0000, 1'b1, 2, S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH);
        while (stim_q.size() > 0) begin
            apply_stimulus();
            want = sb.pop_front(); got = observed(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL undefined %s: got %b want %b", cur_label, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // Z is set from the earlier CMP; reset must clear it, so the BEQ that
    // follows the aborted load is not taken.
    task automatic test_reset_abort();
        add_instr("ldr_abort", 20'hE5910, 4'b0000, 1'b1, 3, S_FETCH, S_DECODE, S_MEMADR, S_FETCH, S_FETCH);
        add_reset("ldr_abort", 20'hE5910, S_MEMRD);
        add_instr("beq_after_reset", 20'h0A000, 4'b0000, 1'b0, 3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH);
        while (stim_q.size() > 0) begin
            apply_stimulus();
            want = sb.pop_front(); got = observed(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset_abort %s: got %b want %b", cur_label, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        $display("[TB] starting arm_mc_controller bench");
        test_reset();
        test_load();
        test_alu_ops();
        test_flags_branch();
        test_bl();
        test_cond_store();
        test_undefined();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run still active at %0t, required to be finished", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Control unit for the multicycle ARM datapath. It holds the main sequencing FSM, decodes the instruction held in the instruction register, and keeps the NZCV flag register plus the registered condition-pass bit. Each cycle it drives the datapath's mux selects and gated write enables. It sits beside the multicycle datapath in the same way the single-cycle control unit sits beside its datapath, and shares the same instruction field layout and 3-bit ALU encoding.

## Interface
Parameters: none.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- Instr  in  20  Instr[31:12] from the instruction register
- ALUFlags  in  4  N,Z,C,V from the ALU; valid in EXECR/EXECI
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- RegSrc  out  2  [0] = read PC as Rn (branch); [1] = read Rd as second source (STR)
- ImmSrc  out  2  equals Instr[27:26]
- ALUSrcA  out  2  00 = RD1, 01 = PC
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 orr, 100 eor
- BrL  out  1  write-address select R14 (BL link write)

## Operation
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH always goes to DECODE.
- From DECODE, on Op = Instr[27:26]:
  - 01 goes to MEMADR.
  - 00 goes to EXECI if Instr[25] = 1, otherwise EXECR.
  - 10 goes to BRANCH.
  - 11 (undefined) goes to FETCH.
- MEMADR goes to MEMRD if L (Instr[20]) = 1, otherwise MEMWR.
- MEMRD goes to MEMWB. MEMWB, MEMWR, ALUWB and BRANCH go to FETCH. EXECR and EXECI go to ALUWB.
- Per-state controls (all unlisted controls are 0):
  - FETCH: IRWrite, raw PCWrite, ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10, ALU add.
  - DECODE: ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10.
  - MEMADR: ALUSrcB = 01, add; offset sign is U, Instr[23], with 0 meaning sub.
  - MEMRD: AdrSrc = 1.
  - MEMWB: ResultSrc = 01, RegW.
  - MEMWR: AdrSrc = 1, MemW.
  - EXECR: ALUSrcB = 00, ALUControl from cmd.
  - EXECI: ALUSrcB = 01, ALUControl from cmd.
  - ALUWB: ResultSrc = 00, RegW unless cmd is CMP.
  - BRANCH: ALUSrcB = 01, ResultSrc = 10, Branch; also RegW and BrL when Instr[24] = 1.
- cmd = Instr[24:21] maps to ALUControl as: 0100 to 000, 0010 to 001, 1010 (CMP) to 001, 0000 to 010, 1100 to 011, 0001 to 100. Any other cmd gives 000 with RegW suppressed.
- Flag write:
  - FlagW[1] (N,Z) = S (Instr[20]) in EXECR/EXECI.
  - FlagW[0] (C,V) = S & (ADD|SUB|CMP).
  - CMP forces FlagW = 11.
  - Flags are captured on the EXECR/EXECI clock edge only if the condition passes.
- Condition: all 15 ARM codes are evaluated on the stored flags in DECODE. Code 1111 means never. The result is latched into CondExR at the DECODE edge.
- Gating:
  - RegWrite = RegW & CondExR.
  - MemWrite = MemW & CondExR.
  - PCWrite = NextPC | ((Branch | (RegW & Rd == 15)) & CondExR), where Rd = Instr[15:12].
- RegSrc[0] = 1 when Op = 10. RegSrc[1] = 1 when Op = 01 and L = 0.

## Timing
- Reset: on the edge with reset high, state goes to FETCH and flags and CondExR go to 0. While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Other outputs show FETCH values.
- All outputs are Moore, combinational from state, Instr, CondExR and reset.
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B/BL 3, undefined 2.
- Reset asserted in any state aborts the instruction; the next cycle is FETCH with no writes committed in the reset cycle.
- A failed condition still walks the full state path, with all writes suppressed.

## Structure
- Package arm_mc_pkg holds:
  - the state enum (typedef statetype_t),
  - ALU encoding localparams,
  - ResultSrc / ALUSrcB encodings,
  - cmd opcode constants.
- Sub-module arm_mc_condlogic holds the flag register, condition evaluation, the CondExR flop and write gating.

## Test plan
- Reset held 2 cycles, then released with Instr = ADD R1,R2,R3 (0xE0821003). Required: writes are 0 during reset; the state sequence is FETCH, DECODE, EXECR, ALUWB; RegWrite = 1 only in ALUWB; ALUControl = 000 in EXECR.
- LDR R0,[R1,#4] (0xE5910004). Required: 5 cycles; AdrSrc = 1 in MEMRD; RegWrite = 1 with ResultSrc = 01 in MEMWB.
- SUBS with ALUFlags = 0100 (Z), then BEQ (0x0A000002). Required: flags are captured; BRANCH asserts PCWrite. With flags 0000, BEQ gives PCWrite = 0 in BRANCH.
- BL (0xEB000001). Required: in BRANCH, RegWrite = 1, BrL = 1 and PCWrite = 1.
- STR with condition NE while Z = 1. Required: MemWrite stays 0 in MEMWR and the FSM still returns to FETCH.
- Instruction with Op = 11. Required: FETCH, DECODE, FETCH, with no writes. Reset asserted in MEMRD: next state FETCH and no RegWrite.
